mem_sram_bridge: RTL

Request bridge between the MEM pipeline stage and the SRAM controller. Accepts one byte-addressed load/store per instruction and performs the access as a single word request with per-byte enables. Stalls the pipeline until the controller reports success, then returns sign- or zero-extended load data and releases the request for one cycle so the controller returns to idle. Misaligned accesses are trapped locally and never reach the SRAM.

---
 rtl/mem_sram_bridge_if.sv | 36 +++
 rtl/mem_sram_bridge.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_sram_bridge_if.sv
// Bus between the MEM pipeline stage, the bridge and the SRAM controller.
// Handshake: the pipeline presents memOp_i/memAddr_i/memData_i and treats
// stall_o as "not ready"; a request is taken in the cycle stall_o rises from
// IDLE and must not be re-presented once the bridge reaches DONE. Towards the
// controller, ramOp_o != 0 is "valid" and is held stable until success_i
// (the controller's "done") is seen, after which ramOp_o drops for one cycle.
interface mem_sram_bridge_if;
  logic [3:0]  memOp_i;
  logic [31:0] memAddr_i;
  logic [31:0] memData_i;
  logic        stall_o;
  logic [31:0] loadData_o;
  logic        adel_o;
  logic        ades_o;
  logic        timeout_o;
  logic [3:0]  ramOp_o;
  logic [19:0] ramAddr_o;
  logic [31:0] storeData_o;
  logic [3:0]  be_n_o;
  logic [31:0] loadData_i;
  logic        success_i;

  // Bridge side
  modport slave (
    input  memOp_i, memAddr_i, memData_i, loadData_i, success_i,
    output stall_o, loadData_o, adel_o, ades_o, timeout_o,
           ramOp_o, ramAddr_o, storeData_o, be_n_o
  );

  // Environment side (pipeline plus SRAM controller)
  modport master (
    output memOp_i, memAddr_i, memData_i, loadData_i, success_i,
    input  stall_o, loadData_o, adel_o, ades_o, timeout_o,
           ramOp_o, ramAddr_o, storeData_o, be_n_o
  );
endinterface

// File: rtl/mem_sram_bridge.sv
// MEM-stage to SRAM-controller bridge: one word access per load/store with
// byte enables, local misalignment traps, load extension and a BUSY timeout.
module mem_sram_bridge #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk50,
  input  logic                rst,
  mem_sram_bridge_if.slave    bus,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [3:0]  ramOp_q;
  logic [19:0] ramAddr_q;
  logic [31:0] storeData_q;
  logic [3:0]  be_n_q;
  logic [1:0]  lane_q;
  logic [7:0]  cnt_q;
  logic [31:0] loadData_q;
  logic        timeout_q;

  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        misaligned, accept;
  logic [1:0]  lane;
  logic [3:0]  be_n_d;
  logic [31:0] storeData_d;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] loadData_d;
  logic        unused_addr;

  assign unused_addr = ^bus.memAddr_i[31:22];
  assign lane        = bus.memAddr_i[1:0];

  // Classify the incoming op and build lane enables / replicated store data
  always_comb begin
    is_load     = (bus.memOp_i >= 4'd1) && (bus.memOp_i <= 4'd5);
    is_store    = (bus.memOp_i >= 4'd6) && (bus.memOp_i <= 4'd8);
    is_byte     = (bus.memOp_i == 4'd1) || (bus.memOp_i == 4'd2) || (bus.memOp_i == 4'd6);
    is_half     = (bus.memOp_i == 4'd3) || (bus.memOp_i == 4'd4) || (bus.memOp_i == 4'd7);
    is_word     = (bus.memOp_i == 4'd5) || (bus.memOp_i == 4'd8);
    misaligned  = (is_half && lane[0]) || (is_word && (lane != 2'd0));
    accept      = (state_q == S_IDLE) && (is_load || is_store) && !misaligned;
    be_n_d      = 4'hF;
    storeData_d = 32'h0;
    if (is_byte)      be_n_d = ~(4'b0001 << lane);
    else if (is_half) be_n_d = lane[1] ? 4'b0011 : 4'b1100;
    else if (is_word) be_n_d = 4'b0000;
    case (bus.memOp_i)
      4'd6:    storeData_d = {4{bus.memData_i[7:0]}};
      4'd7:    storeData_d = {2{bus.memData_i[15:0]}};
      4'd8:    storeData_d = bus.memData_i;
      default: storeData_d = 32'h0;
    endcase
  end

  // Pick the addressed lane out of the raw SRAM word and extend it
  always_comb begin
    shifted    = bus.loadData_i >> {lane_q, 3'b000};
    byte_sel   = shifted[7:0];
    half_sel   = lane_q[1] ? bus.loadData_i[31:16] : bus.loadData_i[15:0];
    loadData_d = 32'h0;
    case (ramOp_q)
      4'd1:    loadData_d = {{24{byte_sel[7]}}, byte_sel};
      4'd2:    loadData_d = {24'h0, byte_sel};
      4'd3:    loadData_d = {{16{half_sel[15]}}, half_sel};
      4'd4:    loadData_d = {16'h0, half_sel};
      4'd5:    loadData_d = bus.loadData_i;
      default: loadData_d = 32'h0;
    endcase
  end

  // Request FSM; all controller-facing outputs are registered here
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ramOp_q     <= 4'h0;
      ramAddr_q   <= 20'h0;
      storeData_q <= 32'h0;
      be_n_q      <= 4'hF;
      lane_q      <= 2'd0;
      cnt_q       <= 8'h0;
      loadData_q  <= 32'h0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          loadData_q <= 32'h0;
          timeout_q  <= 1'b0;
          if (accept) begin
            state_q     <= S_BUSY;
            ramOp_q     <= bus.memOp_i;
            ramAddr_q   <= bus.memAddr_i[21:2];
            lane_q      <= lane;
            be_n_q      <= be_n_d;
            storeData_q <= storeData_d;
            cnt_q       <= 8'h0;
          end
        end
        S_BUSY: begin
          if (bus.success_i || (cnt_q == CNT_LAST)) begin
            // Stores yield 0 from the extractor; a timeout forces 0 too
            loadData_q  <= bus.success_i ? loadData_d : 32'h0;
            timeout_q   <= !bus.success_i;
            state_q     <= S_DONE;
            ramOp_q     <= 4'h0;
            be_n_q      <= 4'hF;
            storeData_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          // DONE: the op on the bus now belongs to the retiring instruction
          state_q    <= S_IDLE;
          loadData_q <= 32'h0;
          timeout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_o     = accept || (state_q == S_BUSY);
  assign bus.adel_o      = (state_q == S_IDLE) && is_load && misaligned;
  assign bus.ades_o      = (state_q == S_IDLE) && is_store && misaligned;
  assign bus.loadData_o  = loadData_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.ramOp_o     = ramOp_q;
  assign bus.ramAddr_o   = ramAddr_q;
  assign bus.storeData_o = storeData_q;
  assign bus.be_n_o      = be_n_q;
  assign state_o         = state_q;

endmodule
